matrix_result_streamer: RTL and testbench

MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

---
 rtl/matrix_pkg.sv | 8 +
 rtl/matrix_elem_relu.sv | 11 +
 rtl/matrix_result_streamer.sv | 109 ++++++++++
 tb/tb_matrix_result_streamer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix blocks (streamer, dot product).
package matrix_pkg;
    localparam int DEFAULT_DATA_W = 32;

    typedef logic [0:0] state_t;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;
endpackage

// File: rtl/matrix_elem_relu.sv
// Combinational clamp of a signed element to max(x, 0).
module matrix_elem_relu
    import matrix_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);
    assign o_data = i_data[DATA_W-1] ? '0 : i_data;
endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a flattened m1 x n2 result and streams it row-major over a valid/ready port.
// Build option: MATRIX_STREAM_RELU_EN clamps negative elements to zero on out_data.
module matrix_result_streamer
    import matrix_pkg::*;
#(
    parameter int m1     = 2,
    parameter int n2     = 2,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [m1*n2*DATA_W-1:0]  result_matrix,
    output logic                     busy,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(m1):0]      out_row,
    output logic [$clog2(n2):0]      out_col,
    output logic                     out_last,
    output logic                     done
);
    localparam int NUM   = m1 * n2;
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int ROW_W = $clog2(m1) + 1;
    localparam int COL_W = $clog2(n2) + 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(n2 - 1);

    state_t                    r_state;
    logic [NUM*DATA_W-1:0]     r_mat;
    logic [IDX_W-1:0]          r_idx;
    logic [ROW_W-1:0]          r_row;
    logic [COL_W-1:0]          r_col;
    logic                      r_done;

    logic                      w_stream;
    logic                      w_last;
    logic                      w_hs;
    logic [DATA_W-1:0]         w_elems [NUM];
    logic [DATA_W-1:0]         w_elem_raw;
    logic [DATA_W-1:0]         w_elem_out;

    for (genvar gi = 0; gi < NUM; gi++) begin : g_elem
        assign w_elems[gi] = r_mat[gi*DATA_W +: DATA_W];
    end

    assign w_stream   = (r_state == ST_STREAM);
    assign w_last     = w_stream && (r_idx == IDX_LAST);
    assign w_hs       = w_stream && out_ready;
    assign w_elem_raw = w_elems[r_idx];

`ifdef MATRIX_STREAM_RELU_EN
    matrix_elem_relu #(.DATA_W(DATA_W)) u_relu (
        .i_data (w_elem_raw),
        .o_data (w_elem_out)
    );
`else
    assign w_elem_out = w_elem_raw;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_mat   <= '0;
            r_idx   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!w_stream) begin
                if (enable) begin
                    r_state <= ST_STREAM;
                    r_mat   <= result_matrix;
                    r_idx   <= '0;
                    r_row   <= '0;
                    r_col   <= '0;
                end
            end else if (w_hs) begin
                if (w_last) begin
                    // Indices park at zero so the idle outputs match the reset state.
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                    r_idx   <= '0;
                    r_row   <= '0;
                    r_col   <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_col == COL_LAST) begin
                        r_col <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
            end
        end
    end

    assign busy      = w_stream;
    assign out_valid = w_stream;
    assign out_last  = w_last;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_data  = w_stream ? w_elem_out : '0;
    assign done      = r_done;
endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench with a queue scoreboard for the 2x2 streamer plus a 1x1 instance.
module tb_matrix_result_streamer;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic [4*DW-1:0] result_matrix = '0;
    logic            busy, out_valid, out_ready = 1'b0, out_last, done;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_row, out_col;

    logic            enable1 = 1'b0, out_ready1 = 1'b0;
    logic [DW-1:0]   mat1 = '0;
    logic            busy1, out_valid1, out_last1, done1;
    logic [DW-1:0]   out_data1;
    logic [0:0]      out_row1, out_col1;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic [1:0]    c;
        logic          l;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    matrix_result_streamer #(.m1(2), .n2(2), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .result_matrix(result_matrix),
        .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .done(done)
    );

    matrix_result_streamer #(.m1(1), .n2(1), .DATA_W(DW)) dut1 (
        .clk(clk), .reset(reset), .enable(enable1), .result_matrix(mat1),
        .busy(busy1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_row(out_row1), .out_col(out_col1), .out_last(out_last1), .done(done1)
    );

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
`ifdef MATRIX_STREAM_RELU_EN
        return x[DW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [4*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [4*DW-1:0] m;
        m[0*DW +: DW] = DW'(a);
        m[1*DW +: DW] = DW'(b);
        m[2*DW +: DW] = DW'(c);
        m[3*DW +: DW] = DW'(d);
        return m;
    endfunction

    task automatic push_matrix(input logic [4*DW-1:0] m);
        exp_t e;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                e.d = relu(m[(r*2+c)*DW +: DW]);
                e.r = 2'(r);
                e.c = 2'(c);
                e.l = (r == 1) && (c == 1);
                q.push_back(e);
            end
    endtask

    // One clock: drive inputs, advance the model across the edge, check outputs just after it.
    task automatic tick(input logic rdy, input logic en, input logic rst);
        exp_t            e;
        bit              hs, ld, dn;
        logic [4*DW-1:0] m;
        out_ready = rdy;
        enable    = en;
        reset     = rst;
        m  = result_matrix;
        hs = rst && (q.size() != 0) && rdy;
        ld = rst && en && (q.size() == 0);
        dn = 1'b0;
        @(posedge clk);
        #1;
        if (!rst) q.delete();
        else begin
            if (hs) begin
                e  = q.pop_front();
                dn = e.l;
            end
            if (ld) push_matrix(m);
        end
        chk("busy", 64'(busy), 64'(q.size() != 0));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("done", 64'(done), 64'(dn));
        if (q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(q[0].d));
            chk("out_row", 64'(out_row), 64'(q[0].r));
            chk("out_col", 64'(out_col), 64'(q[0].c));
            chk("out_last", 64'(out_last), 64'(q[0].l));
        end else begin
            chk("idle_last", 64'(out_last), 64'd0);
        end
    endtask

    initial begin
        // reset state
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_row", 64'(out_row), 64'd0);
        chk("rst_col", 64'(out_col), 64'd0);

        // basic stream 1,2,3,4 with ready held high
        result_matrix = pack4(1, 2, 3, 4);
        tick(1'b1, 1'b1, 1'b1);
        chk("first_elem", 64'(out_data), 64'd1);
        repeat (5) tick(1'b1, 1'b0, 1'b1);

        // backpressure on element 1
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        chk("held_data", 64'(out_data), 64'd2);
        chk("held_col", 64'(out_col), 64'd1);
        repeat (4) tick(1'b1, 1'b0, 1'b1);

        // input change and enable during stream are ignored
        result_matrix = pack4(1, 2, 3, 4);
        tick(1'b1, 1'b1, 1'b1);
        result_matrix = pack4(9, 9, 9, 9);
        repeat (4) tick(1'b1, 1'b1, 1'b1);
        repeat (2) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        chk("second_load", 64'(out_data), 64'd9);
        repeat (5) tick(1'b1, 1'b0, 1'b1);

        // reset mid-stream, enable held during reset
        result_matrix = pack4(5, 6, 7, 8);
        tick(1'b1, 1'b1, 1'b1);
        repeat (2) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        chk("post_rst_done", 64'(done), 64'd0);
        result_matrix = pack4(-3, 4, -1, 7);
        tick(1'b1, 1'b1, 1'b1);
        chk("restart_row", 64'(out_row), 64'd0);
        chk("restart_col", 64'(out_col), 64'd0);
        repeat (5) tick(1'b1, 1'b0, 1'b1);

        // 1x1 instance with a negative element
        mat1 = DW'(-5);
        enable1 = 1'b1;
        @(posedge clk); #1;
        enable1 = 1'b0;
        mat1 = DW'(11);
        chk("u1_valid", 64'(out_valid1), 64'd1);
        chk("u1_busy", 64'(busy1), 64'd1);
        chk("u1_last", 64'(out_last1), 64'd1);
        chk("u1_data", 64'(out_data1), 64'(relu(DW'(-5))));
        chk("u1_row", 64'(out_row1), 64'd0);
        chk("u1_col", 64'(out_col1), 64'd0);
        chk("u1_done_early", 64'(done1), 64'd0);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        chk("u1_valid_after", 64'(out_valid1), 64'd0);
        chk("u1_done", 64'(done1), 64'd1);
        @(posedge clk); #1;
        chk("u1_done_pulse", 64'(done1), 64'd0);
        chk("u1_idle", 64'(busy1), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
